cic_ctrl: RTL and testbench

CIC_CTRL -- requirements
Module: cic_ctrl

---
 rtl/cic_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cic_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_ctrl.sv
// CIC decimator controller: sequences the CIC reset/flush, generates the
// decimation tick, discards the warm-up outputs, then captures, scales and
// saturates each decimated word into a one-deep output register.
//
// Output handshake: sample is offered while sample_valid=1 and is consumed
// on any rising edge where sample_valid=1 and sample_ready=1; a new word may
// be loaded on that same edge. A word arriving while the previous one is
// still unconsumed is dropped and flagged on the sticky overrun output.
module cic_ctrl #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              ratio,
    input  logic [4:0]              shift,
    input  logic [2:0]              warmup,
    input  logic signed [IN_W-1:0]  cic_val,
    output logic                    cic_rst,
    output logic                    dec_tick,
    output logic signed [OUT_W-1:0] sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, FLUSH, WARMUP, RUN} state_t;

    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             ratio_q;
    logic [4:0]             shift_q;
    logic [2:0]             warmup_q;
    logic [7:0]             ratio_eff;
    logic [7:0]             dec_cnt;
    logic [2:0]             wu_cnt;
    logic                   flush_cnt;
    logic                   cap_pend;
    logic                   counting;
    logic                   load_try;
    logic                   load_ok;
    logic signed [IN_W-1:0] shifted;
    logic signed [IN_W-1:0] clamped;

    // Ratio 0 would give a decimation of 1; treat it as 1 (decimate by 2).
    assign ratio_eff = (ratio_q == 8'd0) ? 8'd1 : ratio_q;
    assign counting  = (state == WARMUP) || (state == RUN);
    assign dec_tick  = counting && (dec_cnt == ratio_eff);
    assign cic_rst   = (state == IDLE) || (state == FLUSH);
    assign busy      = (state != IDLE);

    // A capture is only meaningful while still running; a disable drops it.
    assign load_try  = cap_pend && (state == RUN) && enable;
    assign load_ok   = load_try && (!sample_valid || sample_ready);

    // Scale: sign-extending right shift, then clamp into the OUT_W range.
    always_comb begin
        shifted = cic_val >>> shift_q;
        clamped = shifted;
        if (shifted > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            clamped = SAT_MIN;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = FLUSH;
            end
            FLUSH: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (flush_cnt) begin
                    state_next = (warmup_q == 3'd0) ? RUN : WARMUP;
                end
            end
            WARMUP: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (dec_tick && (wu_cnt == warmup_q - 3'd1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Configuration is sampled only on the cycle that leaves IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ratio_q  <= '0;
            shift_q  <= '0;
            warmup_q <= '0;
        end else if ((state == IDLE) && enable) begin
            ratio_q  <= ratio;
            shift_q  <= shift;
            warmup_q <= warmup;
        end
    end

    // Flush length, decimation, warm-up counters and the capture strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= 1'b0;
            dec_cnt   <= '0;
            wu_cnt    <= '0;
            cap_pend  <= 1'b0;
        end else begin
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
            if (counting && enable) begin
                dec_cnt <= dec_tick ? 8'd0 : dec_cnt + 8'd1;
            end else begin
                dec_cnt <= '0;
            end
            if (state == IDLE) begin
                wu_cnt <= '0;
            end else if ((state == WARMUP) && dec_tick) begin
                wu_cnt <= wu_cnt + 3'd1;
            end
            // Comb register needs one cycle after the tick before it is valid.
            cap_pend <= (state == RUN) && enable && dec_tick;
        end
    end

    // Output word register, valid flag and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if ((state != IDLE) && !enable) begin
                sample_valid <= 1'b0;
            end else if (load_ok) begin
                sample       <= clamped[OUT_W-1:0];
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (load_try && !load_ok) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_ctrl.sv
// Bench for cic_ctrl: directed and randomized runs against a cycle-level
// behavioural model; accepted words are checked through an expected queue.
module tb_cic_ctrl;

    logic               clk;
    logic               reset;
    logic               enable;
    logic [7:0]         ratio;
    logic [4:0]         shift;
    logic [2:0]         warmup;
    logic signed [23:0] cic_val;
    logic               cic_rst;
    logic               dec_tick;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               sample_ready;
    logic               overrun;
    logic               overrun_clr;
    logic               busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;

    logic [15:0] exp_q[$];

    // Model of the controller: phase 0 idle, 1 flush, 2 counting.
    int m_phase = 0;
    int m_fc    = 0;
    int m_k     = 0;
    int m_R     = 1;
    int m_sh    = 0;
    int m_wu    = 0;
    int m_word  = 0;
    bit m_cap   = 0;
    bit m_valid = 0;
    bit m_over  = 0;
    bit m_init  = 0;

    cic_ctrl #(.IN_W(24), .OUT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ratio        (ratio),
        .shift        (shift),
        .warmup       (warmup),
        .cic_val      (cic_val),
        .cic_rst      (cic_rst),
        .dec_tick     (dec_tick),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .busy         (busy)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int scale(input logic [23:0] v, input int sh);
        int x;
        x = $signed(v);
        x = x >>> sh;
        if (x > 32767)  x = 32767;
        if (x < -32768) x = -32768;
        return x;
    endfunction

    function automatic bit exp_tick();
        return (m_phase == 2) && ((m_k % (m_R + 1)) == m_R);
    endfunction

    // Reference model: advances on each rising edge using that cycle's inputs.
    initial begin : model
        bit tick;
        bit ld_try;
        bit ld_ok;
        int j;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_phase = 0;
                m_valid = 0;
                m_over  = 0;
                m_cap   = 0;
                m_word  = 0;
                exp_q.delete();
                m_init  = 1;
            end else begin
                tick   = exp_tick();
                j      = m_k / (m_R + 1);
                ld_try = (m_phase == 2) && enable && m_cap;
                ld_ok  = ld_try && (!m_valid || sample_ready);
                if (m_phase != 0 && !enable) begin
                    if (m_valid && !sample_ready && exp_q.size() > 0) void'(exp_q.pop_back());
                    m_valid = 0;
                end else if (ld_ok) begin
                    m_word  = scale(cic_val, m_sh);
                    exp_q.push_back(m_word[15:0]);
                    m_valid = 1;
                end else if (m_valid && sample_ready) begin
                    m_valid = 0;
                end
                if (ld_try && !ld_ok) m_over = 1;
                else if (overrun_clr) m_over = 0;
                // Ticks from index warmup onward occur in RUN and trigger a capture.
                m_cap = tick && (j >= m_wu) && enable;
                case (m_phase)
                    0: if (enable) begin
                        m_phase = 1;
                        m_fc    = 0;
                        m_R     = (ratio == 8'd0) ? 1 : int'(ratio);
                        m_sh    = int'(shift);
                        m_wu    = int'(warmup);
                    end
                    1: if (!enable) m_phase = 0;
                       else if (m_fc == 1) begin
                           m_phase = 2;
                           m_k     = 0;
                       end else m_fc = 1;
                    default: if (!enable) m_phase = 0;
                             else m_k++;
                endcase
            end
        end
    end

    // Monitor: state-derived outputs compared mid-cycle.
    always @(negedge clk) begin
        if (m_init) begin
            chk("dec_tick", int'(dec_tick), int'(exp_tick()));
            chk("cic_rst", int'(cic_rst), int'(m_phase < 2));
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("sample_valid", int'(sample_valid), int'(m_valid));
            chk("overrun", int'(overrun), int'(m_over));
            chk("sample_hold", int'(sample), m_word);
        end
    end

    // Scoreboard: every accepted word must match the head of the queue.
    always @(posedge clk) begin
        if (m_init && !reset && sample_valid === 1'b1 && sample_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_unexpected: got %0d expected no word", sample);
            end else begin
                chk("accept_word", int'(sample), int'($signed(exp_q.pop_front())));
                n_acc++;
            end
        end
    end

    // Stimulus: one enabled run then disable and idle. vmode picks cic_val
    // pattern, rmode picks consumer behaviour, rst_at injects a reset.
    task automatic run(input int r, input int sh, input int wu, input int len,
                       input int vmode, input int rmode, input int rst_at);
        @(negedge clk);
        ratio  = 8'(r);
        shift  = 5'(sh);
        warmup = 3'(wu);
        enable = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            reset  = (i == rst_at);
            ratio  = 8'($urandom_range(0, 255));
            shift  = 5'($urandom_range(0, 31));
            warmup = 3'($urandom_range(0, 7));
            case (vmode)
                0: cic_val = 24'($urandom);
                1: cic_val = 24'sd100;
                2: cic_val = (i % 2 == 0) ? 24'sh7FFFFF : 24'sh800000;
                default: cic_val = ($urandom_range(0, 1) == 1) ? 24'sh7FFFFF : 24'sh800000;
            endcase
            case (rmode)
                0: sample_ready = 1'b1;
                1: sample_ready = ($urandom_range(0, 2) != 0);
                default: sample_ready = 1'b0;
            endcase
            overrun_clr = (rmode == 1) && ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        reset       = 1'b0;
        enable      = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        sample_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        ratio        = '0;
        shift        = '0;
        warmup       = '0;
        cic_val      = '0;
        sample_ready = 1'b0;
        overrun_clr  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Directed runs.
        run(31, 0, 0, 140, 0, 0, -1);
        run(3, 0, 2, 60, 1, 0, -1);
        run(1, 4, 0, 40, 2, 0, -1);
        run(1, 4, 0, 40, 2, 1, -1);
        run(2, 0, 0, 40, 0, 2, -1);
        run(0, 0, 0, 30, 0, 0, -1);
        run(2, 3, 1, 50, 0, 1, 30);
        // Randomized runs, including very short ones that stop in FLUSH.
        for (int n = 0; n < 40; n++) begin
            run($urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 3),
                $urandom_range(1, 120), $urandom_range(0, 3), $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0) ? $urandom_range(5, 40) : -1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (n_acc == 0) begin
            n_bad++;
            $display("FAIL accepted_words: got %0d expected nonzero", n_acc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
